aclk_controller: RTL and testbench
==================================

// Module: aclk_controller
// PURPOSE
//  Keypad/button sequencing FSM for the 24-hr alarm clock. Decides when the LCD driver shows
//  the alarm time or the keyed-in time (show_alarm / show_new_time) and when keyed digits are
//  shifted into the key register and committed as new alarm time or new current time.
//  Sits between the keypad/buttons and the key register, alarm register, timegen and aclk_lcd_driver.
// PARAMETERS
//  TIMEOUT_SEC  10  one_second pulses of keypad inactivity before entry is abandoned
//  CNT_W         4  timeout counter width, must hold TIMEOUT_SEC
// PORTS
//  clk            in   1  system clock, all logic on rising edge
//  reset          in   1  synchronous, active-high
//  one_second     in   1  1-cycle pulse per second from timegen
//  key            in   4  keypad code: 0-9 digit, 10-15 = no key (NOKEY)
//  alarm_button   in   1  level, high while alarm button held
//  time_button    in   1  level, high while time button held
//  shift_key      out  1  1-cycle strobe: shift current key into key register
//  show_new_time  out  1  LCD driver shows key register contents
//  show_alarm     out  1  LCD driver shows alarm register
//  load_new_a     out  1  1-cycle strobe: key register -> alarm register
//  load_new_c     out  1  1-cycle strobe: key register -> current time (timegen)
// BEHAVIOUR
//  - Moore FSM; outputs decoded from state register only. Reset: state SHOW_TIME, all outputs 0,
//    timeout counter 0. Reset asserted mid-entry discards entry; no strobe issued in reset cycle.
//  - SHOW_TIME (no outputs): alarm_button -> SHOW_ALARM; else key is digit -> KEY_STORED; else stay.
//  - KEY_STORED (shift_key=1): unconditionally -> KEY_WAIT. Exactly one shift per key press.
//  - KEY_WAIT (show_new_time=1): key==NOKEY -> KEY_ENTRY; else timeout -> SHOW_TIME; else stay
//    (held key never re-shifts).
//  - KEY_ENTRY (show_new_time=1), priority alarm_button > time_button > digit key > timeout:
//    -> SET_ALARM_TIME / SET_CURRENT_TIME / KEY_STORED / SHOW_TIME.
//  - SHOW_ALARM (show_alarm=1): alarm_button==0 -> SHOW_TIME; key input ignored.
//  - SET_ALARM_TIME (load_new_a=1), SET_CURRENT_TIME (load_new_c=1): 1 cycle, -> SHOW_TIME.
//  - At most one of shift_key/show_new_time/show_alarm/load_new_a/load_new_c high, except
//    none in SHOW_TIME; strobes are exactly 1 cycle wide.
//  - Timeout counter: cleared in every state except KEY_WAIT/KEY_ENTRY (so cleared each new key);
//    in those, +1 on one_second, saturating at TIMEOUT_SEC. timeout = (count==TIMEOUT_SEC).
//    FSM leaves on the cycle after the TIMEOUT_SEC-th pulse is counted.
//  - Latency: key press -> shift_key next cycle; button in KEY_ENTRY -> load strobe next cycle.
// CONFIGURATION
//  ACLK_KEY_TIMEOUT_EN defined: timeout behaviour above.
//  Not defined: counter not instantiated, timeout tied 0; KEY_WAIT/KEY_ENTRY wait indefinitely
//  for release/button/key; all other behaviour identical.
// STRUCTURE
//  aclk_pkg: state encoding localparams (7 states, binary), NOKEY=4'd10, is_digit(key) function.
//  Sub-module aclk_timeout_cnt (clk, reset, clear, one_second, timeout) under ACLK_KEY_TIMEOUT_EN.
// TESTING
//  1 reset high 2 cycles, idle inputs -> all outputs 0, no strobes for 50 cycles.
//  2 key=5 held 3 cycles then NOKEY -> shift_key exactly 1 cycle, show_new_time until exit.
//  3 keys 1,2,3,4 then time_button=1 -> 4 shift_key pulses, then load_new_c 1 cycle, SHOW_TIME.
//  4 key 7 then alarm_button=1 and time_button=1 same cycle -> load_new_a only, load_new_c stays 0.
//  5 SHOW_TIME, alarm_button=1 for 5 cycles with key=8 -> show_alarm 5 cycles, no shift_key.
//  6 key 3 then 10 one_second pulses idle (EN defined) -> back to SHOW_TIME, no load strobe;
//    undefined -> show_new_time stays high; key mid-count restarts the 10-pulse window.

Source files
------------

// File: rtl/aclk_pkg.sv
// Shared state encoding and keypad helpers for the alarm clock controller.
package aclk_pkg;

    typedef enum logic [2:0] {
        SHOW_TIME        = 3'd0,
        KEY_STORED       = 3'd1,
        KEY_WAIT         = 3'd2,
        KEY_ENTRY        = 3'd3,
        SHOW_ALARM       = 3'd4,
        SET_ALARM_TIME   = 3'd5,
        SET_CURRENT_TIME = 3'd6
    } state_t;

    localparam logic [3:0] NOKEY = 4'd10;

    // Codes 10-15 all mean "no key pressed".
    function automatic logic is_digit(input logic [3:0] k);
        return (k < NOKEY);
    endfunction

endpackage

// File: rtl/aclk_timeout_cnt.sv
// Keypad inactivity counter: counts one_second pulses, saturates at TIMEOUT_SEC.
module aclk_timeout_cnt
    import aclk_pkg::*;
#(
    parameter int unsigned TIMEOUT_SEC = 10,
    parameter int unsigned CNT_W       = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic one_second,
    output logic timeout
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_SEC);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (one_second && (count != LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    assign timeout = (count == LIMIT);

endmodule

// File: rtl/aclk_controller.sv
// Keypad/button sequencing FSM for the alarm clock (Moore outputs).
// Optional keypad inactivity timeout enabled by defining ACLK_KEY_TIMEOUT_EN.
module aclk_controller
    import aclk_pkg::*;
#(
    parameter int unsigned TIMEOUT_SEC = 10,
    parameter int unsigned CNT_W       = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       one_second,
    input  logic [3:0] key,
    input  logic       alarm_button,
    input  logic       time_button,
    output logic       shift_key,
    output logic       show_new_time,
    output logic       show_alarm,
    output logic       load_new_a,
    output logic       load_new_c
);

    state_t state, next_state;
    logic   timeout;

`ifdef ACLK_KEY_TIMEOUT_EN
    logic cnt_clear;

    // Counting only runs while an entry is pending, so each new key restarts the window.
    assign cnt_clear = (state != KEY_WAIT) && (state != KEY_ENTRY);

    aclk_timeout_cnt #(
        .TIMEOUT_SEC (TIMEOUT_SEC),
        .CNT_W       (CNT_W)
    ) u_timeout_cnt (
        .clk        (clk),
        .reset      (reset),
        .clear      (cnt_clear),
        .one_second (one_second),
        .timeout    (timeout)
    );
`else
    logic unused_timer_inputs;
    assign unused_timer_inputs = ^{one_second, TIMEOUT_SEC[0], CNT_W[0]};
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= SHOW_TIME;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            SHOW_TIME: begin
                if (alarm_button)       next_state = SHOW_ALARM;
                else if (is_digit(key)) next_state = KEY_STORED;
            end
            KEY_STORED: next_state = KEY_WAIT;
            KEY_WAIT: begin
                if (!is_digit(key)) next_state = KEY_ENTRY;
                else if (timeout)   next_state = SHOW_TIME;
            end
            KEY_ENTRY: begin
                if (alarm_button)       next_state = SET_ALARM_TIME;
                else if (time_button)   next_state = SET_CURRENT_TIME;
                else if (is_digit(key)) next_state = KEY_STORED;
                else if (timeout)       next_state = SHOW_TIME;
            end
            SHOW_ALARM: begin
                if (!alarm_button) next_state = SHOW_TIME;
            end
            SET_ALARM_TIME:   next_state = SHOW_TIME;
            SET_CURRENT_TIME: next_state = SHOW_TIME;
            default:          next_state = SHOW_TIME;
        endcase
    end

    always_comb begin
        shift_key     = 1'b0;
        show_new_time = 1'b0;
        show_alarm    = 1'b0;
        load_new_a    = 1'b0;
        load_new_c    = 1'b0;
        unique case (state)
            KEY_STORED:       shift_key     = 1'b1;
            KEY_WAIT:         show_new_time = 1'b1;
            KEY_ENTRY:        show_new_time = 1'b1;
            SHOW_ALARM:       show_alarm    = 1'b1;
            SET_ALARM_TIME:   load_new_a    = 1'b1;
            SET_CURRENT_TIME: load_new_c    = 1'b1;
            default:          ;
        endcase
    end

endmodule

// File: tb/tb_aclk_controller.sv
// Scoreboard bench for aclk_controller; covers both ACLK_KEY_TIMEOUT_EN builds.
module tb_aclk_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       one_second;
    logic [3:0] key;
    logic       alarm_button;
    logic       time_button;
    logic       shift_key, show_new_time, show_alarm, load_new_a, load_new_c;

    // Output vector order: {shift_key, show_new_time, show_alarm, load_new_a, load_new_c}
    localparam logic [4:0] O_NONE = 5'b00000;
    localparam logic [4:0] O_SK   = 5'b10000;
    localparam logic [4:0] O_SNT  = 5'b01000;
    localparam logic [4:0] O_SA   = 5'b00100;
    localparam logic [4:0] O_LA   = 5'b00010;
    localparam logic [4:0] O_LC   = 5'b00001;
    localparam logic [3:0] NK     = 4'd15;

    typedef struct {
        int         id;
        logic [4:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   applied   = 0;
    int   miscompare = 0;
    int   vec_id    = 0;
    bit   stim_done = 0;

    aclk_controller #(
        .TIMEOUT_SEC (10),
        .CNT_W       (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .one_second    (one_second),
        .key           (key),
        .alarm_button  (alarm_button),
        .time_button   (time_button),
        .shift_key     (shift_key),
        .show_new_time (show_new_time),
        .show_alarm    (show_alarm),
        .load_new_a    (load_new_a),
        .load_new_c    (load_new_c)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs and queue the outputs expected after the next rising edge.
    task automatic cyc(input logic rst, input logic [3:0] k, input logic ab,
                       input logic tbn, input logic os, input logic [4:0] exp);
        exp_t e;
        reset        = rst;
        key          = k;
        alarm_button = ab;
        time_button  = tbn;
        one_second   = os;
        e.id  = vec_id;
        e.exp = exp;
        vec_id++;
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: compare DUT outputs just after each rising edge.
    initial begin
        exp_t       e;
        logic [4:0] act;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e   = sb_q.pop_front();
                act = {shift_key, show_new_time, show_alarm, load_new_a, load_new_c};
                applied++;
                if (act !== e.exp) begin
                    miscompare++;
                    $display("FAIL vec%0d outputs{sk,snt,sa,la,lc}: got %b expected %b at %0t",
                             e.id, act, e.exp, $time);
                end
            end
        end
    end

    initial begin
        // 1: reset then idle
        cyc(1, NK, 0, 0, 0, O_NONE);
        cyc(1, NK, 0, 0, 0, O_NONE);
        for (int i = 0; i < 50; i++) cyc(0, NK, 0, 0, (i % 7) == 0, O_NONE);

        // 2: key held 3 cycles, release, then reset mid-entry
        cyc(0, 4'd5, 0, 0, 0, O_SK);
        cyc(0, 4'd5, 0, 0, 0, O_SNT);
        cyc(0, 4'd5, 0, 0, 0, O_SNT);
        cyc(0, NK,   0, 0, 0, O_SNT);
        cyc(0, NK,   0, 0, 0, O_SNT);
        cyc(1, NK,   0, 1, 0, O_NONE);
        cyc(0, NK,   0, 0, 0, O_NONE);

        // 3: four digits then time_button
        for (int d = 1; d <= 4; d++) begin
            cyc(0, 4'(d), 0, 0, 0, O_SK);
            cyc(0, NK,    0, 0, 0, O_SNT);
            cyc(0, NK,    0, 0, 0, O_SNT);
        end
        cyc(0, NK, 0, 1, 0, O_LC);
        cyc(0, NK, 0, 1, 0, O_NONE);
        cyc(0, NK, 0, 0, 0, O_NONE);

        // 4: both buttons together -> alarm load wins
        cyc(0, 4'd7, 0, 0, 0, O_SK);
        cyc(0, NK,   0, 0, 0, O_SNT);
        cyc(0, NK,   0, 0, 0, O_SNT);
        cyc(0, NK,   1, 1, 0, O_LA);
        cyc(0, NK,   0, 0, 0, O_NONE);

        // 5: alarm display ignores keys
        for (int i = 0; i < 5; i++) cyc(0, 4'd8, 1, 0, 0, O_SA);
        cyc(0, NK, 0, 0, 0, O_NONE);
        cyc(0, NK, 0, 0, 0, O_NONE);

        // Buttons in KEY_WAIT are ignored while the key is still held
        cyc(0, 4'd9, 0, 0, 0, O_SK);
        cyc(0, 4'd9, 0, 1, 0, O_SNT);
        cyc(0, 4'd9, 1, 0, 0, O_SNT);
        cyc(0, 4'd12, 0, 0, 0, O_SNT);
        cyc(0, 4'd0, 0, 0, 0, O_SK);
        cyc(0, NK,   0, 0, 0, O_SNT);
        cyc(1, NK,   0, 0, 0, O_NONE);

        // 6a: ten idle seconds after a key
        cyc(0, 4'd3, 0, 0, 0, O_SK);
        cyc(0, NK,   0, 0, 0, O_SNT);
        for (int i = 1; i <= 10; i++) begin
            cyc(0, NK, 0, 0, 1, O_SNT);
`ifdef ACLK_KEY_TIMEOUT_EN
            cyc(0, NK, 0, 0, 0, (i == 10) ? O_NONE : O_SNT);
`else
            cyc(0, NK, 0, 0, 0, O_SNT);
`endif
        end
        cyc(1, NK, 0, 0, 0, O_NONE);
        cyc(0, NK, 0, 0, 0, O_NONE);

        // 6b: a key mid-count restarts the window
        cyc(0, 4'd3, 0, 0, 0, O_SK);
        cyc(0, NK,   0, 0, 0, O_SNT);
        for (int i = 1; i <= 5; i++) begin
            cyc(0, NK, 0, 0, 1, O_SNT);
            cyc(0, NK, 0, 0, 0, O_SNT);
        end
        cyc(0, 4'd4, 0, 0, 0, O_SK);
        cyc(0, NK,   0, 0, 0, O_SNT);
        for (int i = 1; i <= 10; i++) begin
            cyc(0, NK, 0, 0, 1, O_SNT);
`ifdef ACLK_KEY_TIMEOUT_EN
            cyc(0, NK, 0, 0, 0, (i == 10) ? O_NONE : O_SNT);
`else
            cyc(0, NK, 0, 0, 0, O_SNT);
`endif
        end
        cyc(1, NK, 0, 0, 0, O_NONE);
        cyc(0, NK, 0, 0, 0, O_NONE);
        stim_done = 1;
    end

    initial begin
        int budget;
        budget = 0;
        while (!stim_done && budget < 5000) begin
            @(negedge clk);
            budget++;
        end
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
        if (!stim_done || sb_q.size() > 0) begin
            miscompare++;
            $display("FAIL drain: stimulus done=%0d, %0d expectations left, required 1 and 0",
                     stim_done, sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompare);
        $finish;
    end

endmodule
